// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the programmable serial sequence detector.
package seq_det_pkg;

    typedef enum logic {
        MODE_NONOVL = 1'b0,
        MODE_OVL    = 1'b1
    } mode_e;

    // Widest pattern the compare helper handles; callers zero-extend into it.
    localparam int CMP_W = 32;

    // True when the low `len` bits of window and pattern agree.
    function automatic logic masked_match(input logic [CMP_W-1:0] window,
                                          input logic [CMP_W-1:0] pat,
                                          input int unsigned      len);
        logic [CMP_W-1:0] mask;
        mask = (len >= CMP_W) ? '1 : ((CMP_W'(1) << len) - CMP_W'(1));
        return ((window ^ pat) & mask) == '0;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial sequence detector: Mealy match output, registered copy,
// overlapping/non-overlapping modes and a saturating match counter.
module seq_detector_prog #(
    parameter int                 MAX_LEN     = 8,
    parameter int                 CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] DEF_PATTERN = 8'b0011_0110,
    parameter int                 DEF_LEN     = 6,
    parameter logic               DEF_OVERLAP = 1'b1,
    localparam int                LEN_W       = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               out,
    output logic               out_q,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);

    import seq_det_pkg::*;

    localparam int LW1 = LEN_W + 1;

    // Only the newest MAX_LEN-1 history bits can ever take part in a compare.
    logic [MAX_LEN-2:0] r_hist;
    logic [LEN_W-1:0]   r_fill;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    mode_e              r_ovl;
    logic               r_err;
    logic               r_out_q;

    logic [MAX_LEN-1:0] w_window;
    logic               w_accept;
    logic               w_fill_ok;
    logic               w_eq;
    logic               w_out;

    assign w_window  = {r_hist, in};
    assign w_accept  = in_valid && !cfg_load;
    // fill >= len-1, written as fill+1 >= len so len=1 needs no special case.
    assign w_fill_ok = (LW1'(r_fill) + LW1'(1)) >= LW1'(r_len);
    assign w_eq      = masked_match(CMP_W'(w_window), CMP_W'(r_pat), 32'(r_len));
    assign w_out     = !reset && w_accept && !r_err && w_fill_ok && w_eq;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hist  <= '0;
            r_fill  <= '0;
            r_pat   <= DEF_PATTERN;
            r_len   <= LEN_W'(DEF_LEN);
            r_ovl   <= mode_e'(DEF_OVERLAP);
            r_err   <= 1'b0;
            r_out_q <= 1'b0;
        end else begin
            r_out_q <= w_out;
            if (cfg_load) begin
                r_pat  <= cfg_pattern;
                r_len  <= cfg_len;
                r_ovl  <= mode_e'(cfg_overlap);
                r_err  <= (cfg_len == '0) || (cfg_len > LEN_W'(MAX_LEN));
                r_hist <= '0;
                r_fill <= '0;
            end else if (in_valid) begin
                r_hist <= w_window[MAX_LEN-2:0];
                // Non-overlapping mode restarts the fill so no matched bit is reused.
                if (w_out && (r_ovl == MODE_NONOVL)) begin
                    r_fill <= '0;
                end else if (r_fill != LEN_W'(MAX_LEN - 1)) begin
                    r_fill <= r_fill + LEN_W'(1);
                end
            end
        end
    end

    sat_counter #(
        .W(CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .i_inc (w_out),
        .i_clr (cnt_clr),
        .o_cnt (match_cnt)
    );

    assign out     = w_out;
    assign out_q   = r_out_q;
    assign cfg_err = r_err;

endmodule

// File: tb/tb_seq_detector_prog.sv
// Directed bench for seq_detector_prog: a default-width instance plus a 2-bit-counter
// instance driven in parallel to exercise counter saturation.
module tb_seq_detector_prog;

    logic       clk = 1'b0;
    logic       reset;
    logic       in;
    logic       in_valid;
    logic       cfg_load;
    logic [7:0] cfg_pattern;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       cnt_clr;

    logic       out,   out_q,   cfg_err;
    logic [7:0] match_cnt;
    logic       out_s, out_q_s, cfg_err_s;
    logic [1:0] match_cnt_s;

    int   total = 0;
    int   bad   = 0;
    int   step  = 0;
    logic last_out;
    logic exp_err;
    int   cnt_m;
    int   cnt_s_m;

    always #5 clk = ~clk;

    seq_detector_prog dut (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .out         (out),
        .out_q       (out_q),
        .match_cnt   (match_cnt),
        .cfg_err     (cfg_err)
    );

    seq_detector_prog #(.CNT_W(2)) dut_s (
        .clk         (clk),
        .reset       (reset),
        .in          (in),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .cfg_pattern (cfg_pattern),
        .cfg_len     (cfg_len),
        .cfg_overlap (cfg_overlap),
        .cnt_clr     (cnt_clr),
        .out         (out_s),
        .out_q       (out_q_s),
        .match_cnt   (match_cnt_s),
        .cfg_err     (cfg_err_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
        end
    endtask

    // Checks every output mid-cycle, then updates the bench's own expectations.
    task automatic check_cycle(input logic e);
        chk("out",       32'(out),         32'(e));
        chk("out_s",     32'(out_s),       32'(e));
        chk("out_q",     32'(out_q),       32'(last_out));
        chk("out_q_s",   32'(out_q_s),     32'(last_out));
        chk("match_cnt", 32'(match_cnt),   32'(cnt_m));
        chk("cnt_sat",   32'(match_cnt_s), 32'(cnt_s_m));
        chk("cfg_err",   32'(cfg_err),     32'(exp_err));
        chk("cfg_err_s", 32'(cfg_err_s),   32'(exp_err));
    endtask

    task automatic send(input logic b, input logic v, input logic e, input logic clr);
        in       = b;
        in_valid = v;
        cnt_clr  = clr;
        step++;
        @(negedge clk);
        check_cycle(e);
        last_out = e;
        if (clr) begin
            cnt_m   = 0;
            cnt_s_m = 0;
        end else if (e) begin
            if (cnt_m < 255) cnt_m++;
            if (cnt_s_m < 3) cnt_s_m++;
        end
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
    endtask

    // Bits and expected outputs are given first-bit-in-MSB over n positions.
    task automatic stream(input logic [15:0] bits, input int n, input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            send(bits[i], 1'b1, exp[i], 1'b0);
        end
    endtask

    task automatic cfg(input logic [7:0] p, input logic [3:0] l, input logic o,
                       input logic v, input logic b);
        cfg_load    = 1'b1;
        cfg_pattern = p;
        cfg_len     = l;
        cfg_overlap = o;
        in_valid    = v;
        in          = b;
        step++;
        @(negedge clk);
        check_cycle(1'b0);
        last_out = 1'b0;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        exp_err  = (l == 4'd0) || (l > 4'd8);
    endtask

    initial begin
        reset       = 1'b1;
        in          = 1'b0;
        in_valid    = 1'b0;
        cfg_load    = 1'b0;
        cfg_pattern = 8'h00;
        cfg_len     = 4'd0;
        cfg_overlap = 1'b0;
        cnt_clr     = 1'b0;
        last_out    = 1'b0;
        exp_err     = 1'b0;
        cnt_m       = 0;
        cnt_s_m     = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_cycle(1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Default config 110110, overlapping: matches on bits 6 and 9
        stream(16'b110110110, 9, 16'b000001001);

        // Non-overlapping: matches on bits 6 and 12 only
        cfg(8'b0011_0110, 4'd6, 1'b0, 1'b0, 1'b0);
        stream(16'b110110110110, 12, 16'b000001000001);

        // Gap of three idle cycles inside a match
        stream(16'b110, 3, 16'b000);
        repeat (3) send(1'b1, 1'b0, 1'b0, 1'b0);
        stream(16'b110, 3, 16'b001);

        // Length 1, pattern 1
        cfg(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
        stream(16'b1011, 4, 16'b1011);

        // Illegal lengths suppress matches; a legal reload recovers
        cfg(8'h01, 4'd0, 1'b1, 1'b0, 1'b0);
        stream(16'b111, 3, 16'b000);
        cfg(8'h01, 4'd9, 1'b1, 1'b0, 1'b0);
        stream(16'b11, 2, 16'b00);
        cfg(8'h05, 4'd3, 1'b1, 1'b0, 1'b0);
        stream(16'b10101, 5, 16'b00101);

        // cfg_load on the final pattern bit: bit discarded, history cleared
        stream(16'b10, 2, 16'b00);
        cfg(8'h05, 4'd3, 1'b1, 1'b1, 1'b1);
        stream(16'b0101, 4, 16'b0001);

        // cnt_clr coincident with a match
        send(1'b0, 1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b1, 1'b1, 1'b1);
        send(1'b0, 1'b0, 1'b0, 1'b0);

        // Five matches: 2-bit counter saturates at 3
        cfg(8'h01, 4'd1, 1'b1, 1'b0, 1'b0);
        stream(16'b11111, 5, 16'b11111);
        send(1'b0, 1'b0, 1'b0, 1'b0);

        // Async reset mid-pattern after 11011
        cfg(8'b0011_0110, 4'd6, 1'b1, 1'b0, 1'b0);
        stream(16'b11011, 5, 16'b00000);
        in       = 1'b0;
        in_valid = 1'b1;
        step++;
        #2;
        chk("pre_reset_out", 32'(out), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_out",       32'(out),         32'd0);
        chk("rst_out_q",     32'(out_q),       32'd0);
        chk("rst_match_cnt", 32'(match_cnt),   32'd0);
        chk("rst_cnt_sat",   32'(match_cnt_s), 32'd0);
        chk("rst_cfg_err",   32'(cfg_err),     32'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        last_out = 1'b0;
        cnt_m    = 0;
        cnt_s_m  = 0;
        exp_err  = 1'b0;
        stream(16'b0110110, 7, 16'b0000001);
        send(1'b0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detector_prog.md
# seq_detector_prog

Parametrised, runtime-programmable serial sequence detector. It generalises the fixed 110110 Mealy detector:
- pattern and length up to `MAX_LEN` bits, loaded at runtime;
- selectable overlapping or non-overlapping match mode;
- an input-valid qualifier, a registered match copy and a saturating match counter.

It sits on a serial bit stream in front of the frame/marker logic.

## Interface
- `MAX_LEN`, 8: maximum pattern length in bits (≥2).
- `CNT_W`, 8: match counter width.
- `DEF_PATTERN`, 8'b0011_0110: pattern loaded at reset. LSB-aligned, so the low 6 bits are 110110.
- `DEF_LEN`, 6: pattern length loaded at reset.
- `DEF_OVERLAP`, 1: match mode loaded at reset.
- `LEN_W`, $clog2(MAX_LEN+1): derived localparam.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in` in 1: serial data bit.
- `in_valid` in 1: `in` is sampled only when high.
- `cfg_load` in 1: one-cycle strobe that captures `cfg_pattern`, `cfg_len` and `cfg_overlap`.
- `cfg_pattern` in MAX_LEN: the pattern. Bit `len-1` is the first bit received, bit 0 the last.
- `cfg_len` in LEN_W: valid range 1..MAX_LEN.
- `cfg_overlap` in 1: 1 = overlapping, 0 = non-overlapping.
- `cnt_clr` in 1: synchronous clear of `match_cnt`.
- `out` out 1: Mealy match, combinational within the cycle of the last pattern bit.
- `out_q` out 1: `out` registered, one cycle later.
- `match_cnt` out CNT_W: saturating count of matches.
- `cfg_err` out 1: the active config has an illegal length.

## Operation
State registers:
- `hist[MAX_LEN-1:0]`: bit history, shifted left with `in` entering at bit 0.
- `fill`: number of valid history bits, saturating at MAX_LEN-1.
- Active config: `pat`, `len`, `ovl`.
- `err`, `out_q`, `match_cnt`.

Rules:
- **Accepted bit:** a bit is accepted when `in_valid`=1 and `cfg_load`=0. On acceptance, `hist` shifts and `fill` increments (saturating).
- **Match:** `out` = accepted, and `!err`, and `fill >= len-1`, and {`hist[len-2:0]`, `in`} == `pat[len-1:0]`.
  - For `len`=1 the comparison is `in == pat[0]` and the fill condition is always true.
- **Non-overlapping mode** (`ovl`=0): on a match, `fill` <= 0 instead of incrementing, so no bit is reused.
- **Overlapping mode** (`ovl`=1): `fill` advances normally and suffix/prefix reuse is implicit.
- **Config load:** `cfg_load` captures the config, clears `hist` and `fill`, and sets `err` = (`cfg_len`==0 || `cfg_len`>MAX_LEN).
  - While `err`=1, `out` is held at 0 and the history still shifts.
- **Counter:** `match_cnt` increments on `out`=1 and saturates at 2^CNT_W-1. `cnt_clr` zeroes it.
  - `cnt_clr` together with `out` gives `match_cnt`=0; clear wins.
- **Idle input:** `in_valid`=0 gives `out`=0 and leaves the state unchanged. Gaps in the stream do not break a match in progress.

## Timing
- **Reset values:** `hist`=0, `fill`=0, `pat`=DEF_PATTERN, `len`=DEF_LEN, `ovl`=DEF_OVERLAP, `err`=0, `out_q`=0, `match_cnt`=0. `out` is forced 0 while `reset` is high.
- **Latency:** `out` has zero cycles, asserting in the same cycle as the final bit. `out_q` and `match_cnt` update at the following rising edge.
- **`cfg_load` with `in_valid`:** `cfg_load` wins. The bit is discarded and `out`=0 that cycle. The new config takes effect for the bit in the next cycle.
- **Reset mid-pattern:** the partial history is lost, and the next match needs a full `len` bits after reset deasserts.
- **Runtime config:** the reset-default config is lost once `cfg_load` is used; only `reset` restores it.

## Structure
- Package `seq_det_pkg` holds the mode constants (`MODE_NONOVL`=0, `MODE_OVL`=1) and a function computing the length-masked compare.
- No sub-module is required. An optional `sat_counter` (width parameter, inc/clr) may be instantiated for `match_cnt`.
- Target size is 120–250 lines of RTL.

## Test plan
- **Default overlap:** after reset, stream 110110110 with `in_valid`=1. `out` pulses on bits 6 and 9. `out_q` follows one cycle later. `match_cnt`=2.
- **Non-overlap:** load 110110, len 6, `cfg_overlap`=0. Stream 110110110110. `out` pulses on bits 6 and 12 only. `match_cnt`=2.
- **Gaps and length 1:** stream 11011 0 with `in_valid` low for 3 cycles between bits 3 and 4. Expect a match on the last bit. Then load len=1, pattern 1, and stream 1011. Expect `out` on 3 bits.
- **Illegal config:** load `cfg_len`=0, then `cfg_len`=MAX_LEN+1. Expect `cfg_err`=1 and `out` never high. Reload len 3, pattern 101 and stream 10101. Expect 2 matches.
- **Collisions:**
  - `cfg_load` coincident with the final pattern bit: no match and the bit is discarded.
  - `cnt_clr` coincident with a match: `match_cnt`=0.
  - With `CNT_W`=2 and 5 matches: `match_cnt` saturates at 3.
- **Async reset:** assert `reset` mid-pattern (after 11011) between clock edges. All outputs go to 0 immediately. The next 6 bits 110110 are needed for a match.
